// File: rtl/fpu_uart_pkg.sv
// Shared types and constants for the FPU result UART transmitter.
// The transmitter sends one 16-bit result as two 8N1 bytes, high byte first.
package fpu_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam int   UART_DATA_BITS      = 8;
    localparam int   UART_BYTES_PER_WORD = 2;
    localparam int   RESULT_W            = 16;
    localparam logic UART_IDLE_LEVEL     = 1'b1;

    // Byte 0 is the high byte of the word, byte 1 the low byte.
    function automatic logic [7:0] word_byte(input logic [RESULT_W-1:0] w, input logic idx);
        return idx ? w[7:0] : w[15:8];
    endfunction

endpackage

// File: rtl/fpu_result_uart_tx_if.sv
// Valid/ready handshake carrying one Bfloat16 result word into the transmitter.
// The producer drives valid/data; the transmitter drives ready.
interface fpu_result_uart_tx_if;
    import fpu_uart_pkg::*;

    logic                result_valid;
    logic [RESULT_W-1:0] result_data;
    logic                result_ready;

    modport master (output result_valid, output result_data, input result_ready);
    modport slave  (input result_valid, input result_data, output result_ready);

endinterface

// File: rtl/uart_tx_byte.sv
// One-byte 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// A start strobe in the last stop-bit cycle chains the next byte with no gap.
module uart_tx_byte
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_serial,
    output logic       o_done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_serial, w_serial_nxt;
    logic             w_bit_end;
    logic             w_done;

    assign w_bit_end = (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        w_state_nxt   = r_state;
        w_cnt_nxt     = w_bit_end ? '0 : r_cnt + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (i_start) begin
                    w_state_nxt   = ST_START;
                    w_shift_nxt   = i_data;
                    w_bit_idx_nxt = '0;
                end
            end
            ST_START: begin
                if (w_bit_end) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == BIT_LAST) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_done = 1'b1;
                    if (i_start) begin
                        w_state_nxt   = ST_START;
                        w_shift_nxt   = i_data;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level is registered from the next state so it changes on the same edge.
        case (w_state_nxt)
            ST_START: w_serial_nxt = 1'b0;
            ST_DATA:  w_serial_nxt = w_shift_nxt[0];
            default:  w_serial_nxt = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_serial  <= UART_IDLE_LEVEL;
        end else begin
            // NOTE: all state updates are non-blocking so every register sees pre-edge values.
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_serial  <= w_serial_nxt;
        end
    end

    assign o_serial = r_serial;
    assign o_done   = w_done;

endmodule

// File: rtl/fpu_result_uart_tx.sv
// Returns each Bfloat16 FPU result to the host as two back-to-back 8N1 bytes.
// Holds the word, tracks which byte is on the line and owns the handshake.
module fpu_result_uart_tx
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_result_uart_tx_if.slave  res_if,
    output logic                 tx_serial,
    output logic                 tx_active,
    output logic                 tx_done
);

    localparam logic LAST_BYTE = 1'(UART_BYTES_PER_WORD - 1);

    logic [RESULT_W-1:0] r_hold;
    logic                r_active;
    logic                r_byte_sel;
    logic                r_tx_done;
    logic                w_accept;
    logic                w_byte_done;
    logic                w_start;
    logic [7:0]          w_byte_data;

    assign res_if.result_ready = ~r_active;
    assign w_accept = res_if.result_valid & res_if.result_ready;
    assign w_start  = w_accept | (w_byte_done & (r_byte_sel != LAST_BYTE));

    // The first byte bypasses the holding register so the start bit leaves on the accept edge.
    assign w_byte_data = r_active ? word_byte(r_hold, ~r_byte_sel)
                                  : word_byte(res_if.result_data, 1'b0);

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_data   (w_byte_data),
        .o_serial (tx_serial),
        .o_done   (w_byte_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= '0;
            r_active   <= 1'b0;
            r_byte_sel <= 1'b0;
            r_tx_done  <= 1'b0;
        end else begin
            r_tx_done <= w_byte_done & (r_byte_sel == LAST_BYTE);
            if (w_accept) begin
                r_hold     <= res_if.result_data;
                r_active   <= 1'b1;
                r_byte_sel <= 1'b0;
            end else if (w_byte_done) begin
                if (r_byte_sel == LAST_BYTE) begin
                    r_active   <= 1'b0;
                    r_byte_sel <= 1'b0;
                end else begin
                    r_byte_sel <= r_byte_sel + 1'b1;
                end
            end
        end
    end

    assign tx_active = r_active;
    assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Bench for fpu_result_uart_tx: an exact line-pattern scoreboard at 4 clocks/bit
// and a mid-bit sampling UART receiver at 217 clocks/bit.
module tb_fpu_result_uart_tx;

    localparam int CPB   = 4;
    localparam int CPB_B = 217;
    localparam int FRAME = 20 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpu_result_uart_tx_if aif ();
    fpu_result_uart_tx_if bif ();

    logic tx_serial_a, tx_active_a, tx_done_a;
    logic tx_serial_b, tx_active_b, tx_done_b;

    fpu_result_uart_tx #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .res_if    (aif),
        .tx_serial (tx_serial_a),
        .tx_active (tx_active_a),
        .tx_done   (tx_done_a)
    );

    fpu_result_uart_tx #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .res_if    (bif),
        .tx_serial (tx_serial_b),
        .tx_active (tx_active_b),
        .tx_done   (tx_done_b)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int done_a = 0;

    logic [15:0] exp_q[$];
    int          acc_q[$];
    logic [7:0]  exp_b[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (tx_done_a) done_a <= done_a + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected line level for every cycle of a word, first cycle in the MSB.
    function automatic logic [FRAME-1:0] frame_bits(input logic [15:0] w);
        logic [FRAME-1:0] f;
        logic [7:0]       b;
        int               pos;
        f = '0;
        for (int t = 0; t < FRAME; t++) begin
            b   = (t < 10 * CPB) ? w[15:8] : w[7:0];
            pos = (t % (10 * CPB)) / CPB;
            if (pos == 0)      f[FRAME-1-t] = 1'b0;
            else if (pos == 9) f[FRAME-1-t] = 1'b1;
            else               f[FRAME-1-t] = b[pos-1];
        end
        return f;
    endfunction

    // Scoreboard monitor for the fast instance: captures a whole word cycle by cycle.
    initial begin : mon_a
        logic [FRAME-1:0] cap;
        logic [15:0]      w;
        bit               ok;
        bit               aborted;
        int               start;
        forever begin
            @(negedge clk);
            if (!rst && tx_serial_a === 1'b0) begin
                start   = cyc;
                ok      = 1'b1;
                aborted = 1'b0;
                cap     = '0;
                for (int t = 0; t < FRAME; t++) begin
                    if (t > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    cap[FRAME-1-t] = tx_serial_a;
                    if (tx_active_a !== 1'b1 || tx_done_a !== 1'b0 || aif.result_ready !== 1'b0) ok = 1'b0;
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got line %h expected no frame", cap);
                    end else begin
                        w = exp_q.pop_front();
                        check("frame_line", cap, frame_bits(w));
                        check("frame_latency", start, acc_q.pop_front());
                        check("frame_busy_flags", ok, 1'b1);
                        check("frame_end_flags", {tx_done_a, tx_active_a, aif.result_ready, tx_serial_a}, 4'b1011);
                    end
                end
            end
        end
    end

    // Receiver model for the slow instance: samples each bit near its centre.
    initial begin : mon_b
        logic [7:0] b;
        logic       s_start;
        logic       s_stop;
        forever begin
            @(negedge clk);
            if (!rst && tx_serial_b === 1'b0) begin
                repeat (CPB_B / 2) @(negedge clk);
                s_start = tx_serial_b;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB_B) @(negedge clk);
                    b[i] = tx_serial_b;
                end
                repeat (CPB_B) @(negedge clk);
                s_stop = tx_serial_b;
                if (exp_b.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL unexpected_rx_byte: got %h expected none", b);
                end else begin
                    check("rx_byte", b, exp_b.pop_front());
                    check("rx_framing", {s_start, s_stop}, 2'b01);
                end
            end
        end
    end

    // Called on a falling edge; returns the cycle number of the accept edge.
    task automatic send_a(input logic [15:0] w, input bit hold, input bit expect_frame, output int acc);
        int n;
        aif.result_valid = 1'b1;
        aif.result_data  = w;
        n = 0;
        while (aif.result_ready !== 1'b1 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (aif.result_ready !== 1'b1) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_a_timeout: got ready %b expected 1", aif.result_ready);
            aif.result_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (expect_frame) begin
            exp_q.push_back(w);
            acc_q.push_back(acc);
        end
        @(negedge clk);
        if (!hold) aif.result_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] w);
        int n;
        bif.result_valid = 1'b1;
        bif.result_data  = w;
        n = 0;
        while (bif.result_ready !== 1'b1 && n < 30 * CPB_B) begin
            @(negedge clk);
            n++;
        end
        if (bif.result_ready !== 1'b1) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_b_timeout: got ready %b expected 1", bif.result_ready);
        end else begin
            exp_b.push_back(w[15:8]);
            exp_b.push_back(w[7:0]);
            @(negedge clk);
        end
        bif.result_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_timeout: got %0d words pending expected 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    initial begin : stim
        int acc0, acc1, acc2;
        int done_before;
        int n;
        aif.result_valid = 1'b0;
        aif.result_data  = '0;
        bif.result_valid = 1'b0;
        bif.result_data  = '0;

        repeat (2) @(negedge clk);
        check("reset_state", {tx_serial_a, tx_active_a, tx_done_a, aif.result_ready}, 4'b1001);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1.0 in Bfloat16
        send_a(16'h3F80, 1'b0, 1'b1, acc0);
        wait_idle_a();
        @(negedge clk);
        check("done_pulses_first_word", done_a, 1);

        // Back-to-back with valid held: second word starts one idle cycle after done
        send_a(16'h4000, 1'b1, 1'b1, acc1);
        send_a(16'hC040, 1'b0, 1'b1, acc2);
        check("b2b_accept_spacing", acc2 - acc1, FRAME + 1);
        wait_idle_a();

        // Offer arrives mid-frame and its data changes before ready returns
        send_a(16'hA55A, 1'b0, 1'b1, acc0);
        repeat (10) @(negedge clk);
        aif.result_valid = 1'b1;
        aif.result_data  = 16'h1234;
        repeat (20) @(negedge clk);
        check("held_off_ready", aif.result_ready, 1'b0);
        aif.result_data = 16'hFFFF;
        send_a(16'hFFFF, 1'b0, 1'b1, acc1);
        check("held_accept_spacing", acc1 - acc0, FRAME + 1);
        wait_idle_a();
        @(negedge clk);

        // Reset during the data bits of byte 0
        done_before = done_a;
        send_a(16'h0000, 1'b0, 1'b0, acc0);
        repeat (8) @(negedge clk);
        check("pre_reset_line", tx_serial_a, 1'b0);
        #2 rst = 1'b1;
        #1 check("reset_async", {tx_serial_a, tx_active_a, aif.result_ready, tx_done_a}, 4'b1010);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FRAME) @(negedge clk);
        check("no_done_after_reset", done_a, done_before);

        send_a(16'h00FF, 1'b0, 1'b1, acc0);
        wait_idle_a();
        @(negedge clk);
        check("done_pulses_total", done_a, 6);

        // Loopback at the production bit rate
        for (int i = 0; i < 4; i++) send_b(16'($urandom));
        n = 0;
        while (exp_b.size() != 0 && n < 25 * CPB_B) begin
            @(negedge clk);
            n++;
        end
        if (exp_b.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rx_timeout: got %0d bytes pending expected 0", exp_b.size());
        end
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
